mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have ports ms_allowin (out, 1), es_to_ms_valid (in, 1): upstream valid/allowin handshake.
REQ-004 SHALL have es inputs es_pc (32), es_result (32, ALU result / memory vaddr), es_rf_waddr (5), es_rf_we (1) and es_mem_req (1, a data_sram request was issued for this instruction).
REQ-005 SHALL have es inputs es_load_op (5, one-hot {ld_w, ld_hu, ld_h, ld_bu, ld_b}) and es_csr_re (1).
REQ-006 SHALL have es inputs es_ex_zip (87), es_tlb_zip (10) and es_tlb_exc (8), passed through unmodified.
REQ-007 SHALL have inputs data_sram_data_ok (1) and data_sram_rdata (32): in-order response channel, at most 2 requests outstanding system-wide.
REQ-008 SHALL have inputs ws_allowin (1) and wb_flush (1, OR of wb_ex, ertn_flush, wb_refetch_flush).
REQ-009 SHALL have outputs ms_to_ws_valid (1), ms_pc (32), ms_rf_wdata (32), ms_rf_waddr (5), ms_rf_we (1), ms_result (32), ms_csr_re (1), ms_ex_zip (87), ms2ws_tlb_zip (10), ms2ws_tlb_exc (8).
REQ-010 SHALL have forwarding outputs ms_fwd_we (1), ms_fwd_waddr (5), ms_fwd_wdata (32), ms_load_stall (1).
REQ-011 SHALL have output ms_ex_pending (1): valid MS instruction carries an exception or ertn, so ES suppresses new memory requests.

Function
REQ-012 SHALL define ms_ready_go = !ms_mem_req_r | data_ok_hit | buf_valid, where data_ok_hit = data_sram_data_ok & (discard_cnt == 0).
REQ-013 SHALL drive ms_allowin = !ms_valid | (ms_ready_go & ws_allowin) and ms_to_ws_valid = ms_valid & ms_ready_go.
REQ-014 SHALL clear ms_valid when wb_flush is asserted, else load ms_valid with es_to_ms_valid when ms_allowin is 1; flush has priority.
REQ-015 SHALL capture all es_* payload into registers only when es_to_ms_valid & ms_allowin.
REQ-016 SHALL hold rdata in buf_valid/buf_data when data_ok_hit arrives while ms_valid & ms_mem_req_r & !ws_allowin; the buffer clears when the instruction moves to WS or on wb_flush.
REQ-017 SHALL maintain a 2-bit discard_cnt: increment when wb_flush occurs while ms_valid & ms_mem_req_r & !buf_valid & !data_ok_hit.
REQ-018 SHALL decrement discard_cnt on data_sram_data_ok while discard_cnt != 0, and drop that response (no buffer write, no ready_go).
REQ-019 SHALL leave discard_cnt unchanged when an increment and decrement condition coincide; the counter never wraps (max 2).
REQ-020 SHALL select the load source as buf_valid ? buf_data : data_sram_rdata, using byte offset es_result[1:0] (registered).
REQ-021 SHALL extract loads as: ld_b/ld_bu take byte[8*off+7:8*off], sign-/zero-extended; ld_h/ld_hu take halfword at off[1] (off[0] ignored), sign-/zero-extended; ld_w takes the full word.
REQ-022 SHALL drive ms_rf_wdata as the extracted load data when any es_load_op bit is set, else the registered es_result; ms_result always equals the registered es_result.
REQ-023 SHALL drive ms_rf_we = ms_rf_we_r & ms_valid, and mask it when any exception bit in ms_ex_zip or ms2ws_tlb_exc is set.
REQ-024 SHALL drive ms_fwd_we = ms_rf_we, ms_fwd_waddr = ms_rf_waddr and ms_fwd_wdata = ms_rf_wdata.
REQ-025 SHALL drive ms_load_stall = ms_valid & (|load_op) & !ms_ready_go.
REQ-026 SHALL drive ms_ex_pending = ms_valid & (any ex bit | ertn bit of ms_ex_zip | |ms2ws_tlb_exc).
REQ-027 SHALL have zero added latency: a non-memory instruction passes ES->MS->WS in one cycle per stage; a load leaves MS in the cycle data_ok_hit is seen (with ws_allowin=1).

Reset
REQ-028 SHALL, on reset, clear ms_valid, buf_valid and discard_cnt, and zero all payload registers; all outputs are then 0 and ms_allowin=1.
REQ-029 SHALL, if reset is asserted mid-operation, drop any outstanding responses; the system resets the sram side simultaneously.

Verification
REQ-030 SHALL be verified by: ALU op, es_result=0x1234 with ws_allowin=1 -> next cycle ms_to_ws_valid=1, ms_rf_wdata=0x1234.
REQ-031 SHALL be verified by: ld_b at off=3, rdata=0x80FF_0000, data_ok two cycles after entry -> ms_load_stall=1 for 2 cycles, then ms_rf_wdata=0xFFFF_FF80.
REQ-032 SHALL be verified by: ld_hu at off=2, data_ok while ws_allowin=0 for 3 cycles -> buffered, then on release ms_rf_wdata=0x0000_80FF, with the sram output changed meanwhile.
REQ-033 SHALL be verified by: load waiting, wb_flush pulses -> discard_cnt=1, ms_valid=0; the next data_ok is dropped; a following load gets the second data_ok correctly.
REQ-034 SHALL be verified by: wb_flush coinciding with data_ok_hit -> discard_cnt stays 0, ms_valid=0, no write to WS.
REQ-035 SHALL be verified by: an instruction with a syscall bit in es_ex_zip -> ms_ex_pending=1, ms_rf_we=0, ms_ex_zip forwarded bit-exact.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: collects the load response, extracts and extends load data, and forwards to WS.
// Latency: zero added cycles. A non-memory op leaves the cycle after entry; a memory op leaves in the cycle its response is accepted.
// Backpressure: ms_allowin falls while a memory op waits for data_ok or WS stalls. Early responses are parked in a one-entry buffer.
//
// Ports:
//   clk, reset           - single clock, synchronous active-high reset
//   es_* / es_to_ms_valid / ms_allowin - upstream payload and valid/allowin handshake
//   data_sram_*          - in-order response channel (at most 2 requests outstanding)
//   ws_allowin, wb_flush - downstream acceptance and pipeline flush
//   ms_* / ms2ws_*       - payload to WS; ms_fwd_* / ms_load_stall drive the bypass network
//   ms_ex_pending        - MS holds an exception or ertn, so ES must not issue memory requests
//
// ex_zip layout (87 bits): {csr_we, csr_num[13:0], csr_wmask[31:0], csr_wvalue[31:0], ertn, ex[6:0]}.
// Bits [6:0] are exception flags (bit 0 = syscall), bit 7 is ertn, and the rest is CSR payload.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_result,
    input  logic [4:0]  es_rf_waddr,
    input  logic        es_rf_we,
    input  logic        es_mem_req,
    input  logic [4:0]  es_load_op,
    input  logic        es_csr_re,
    input  logic [86:0] es_ex_zip,
    input  logic [9:0]  es_tlb_zip,
    input  logic [7:0]  es_tlb_exc,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    input  logic        wb_flush,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_rf_wdata,
    output logic [4:0]  ms_rf_waddr,
    output logic        ms_rf_we,
    output logic [31:0] ms_result,
    output logic        ms_csr_re,
    output logic [86:0] ms_ex_zip,
    output logic [9:0]  ms2ws_tlb_zip,
    output logic [7:0]  ms2ws_tlb_exc,
    output logic        ms_fwd_we,
    output logic [4:0]  ms_fwd_waddr,
    output logic [31:0] ms_fwd_wdata,
    output logic        ms_load_stall,
    output logic        ms_ex_pending
);

    localparam int EX_W     = 7;
    localparam int ERTN_BIT = 7;

    // load_op one-hot positions
    localparam int LD_B  = 0;
    localparam int LD_BU = 1;
    localparam int LD_H  = 2;
    localparam int LD_HU = 3;
    localparam int LD_W  = 4;

    logic        ms_valid;
    logic [31:0] ms_pc_r;
    logic [31:0] ms_result_r;
    logic [4:0]  ms_rf_waddr_r;
    logic        ms_rf_we_r;
    logic        ms_mem_req_r;
    logic [4:0]  ms_load_op_r;
    logic        ms_csr_re_r;
    logic [86:0] ms_ex_zip_r;
    logic [9:0]  ms_tlb_zip_r;
    logic [7:0]  ms_tlb_exc_r;

    logic        buf_valid;
    logic [31:0] buf_data;
    logic [1:0]  discard_cnt;

    logic        data_ok_hit;
    logic        ms_ready_go;
    logic        es_fire;
    logic        ms_leave;
    logic        ex_flag;
    logic        tlb_flag;
    logic        disc_inc;
    logic        disc_dec;
    logic [31:0] load_src;
    logic [1:0]  load_off;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // A response while discard_cnt is nonzero belongs to a flushed instruction.
    assign data_ok_hit    = data_sram_data_ok & (discard_cnt == 2'd0);
    assign ms_ready_go    = !ms_mem_req_r | data_ok_hit | buf_valid;
    assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    assign es_fire        = es_to_ms_valid & ms_allowin;
    assign ms_leave       = ms_to_ws_valid & ws_allowin;

    assign ex_flag  = |ms_ex_zip_r[EX_W-1:0];
    assign tlb_flag = |ms_tlb_exc_r;

    // An in-flight request that gets flushed leaves one response to discard.
    // If data arrives in the flush cycle, it is already accounted for.
    assign disc_inc = wb_flush & ms_valid & ms_mem_req_r & !buf_valid & !data_ok_hit;
    assign disc_dec = data_sram_data_ok & (discard_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (wb_flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_pc_r       <= 32'b0;
            ms_result_r   <= 32'b0;
            ms_rf_waddr_r <= 5'b0;
            ms_rf_we_r    <= 1'b0;
            ms_mem_req_r  <= 1'b0;
            ms_load_op_r  <= 5'b0;
            ms_csr_re_r   <= 1'b0;
            ms_ex_zip_r   <= 87'b0;
            ms_tlb_zip_r  <= 10'b0;
            ms_tlb_exc_r  <= 8'b0;
        end else if (es_fire) begin
            ms_pc_r       <= es_pc;
            ms_result_r   <= es_result;
            ms_rf_waddr_r <= es_rf_waddr;
            ms_rf_we_r    <= es_rf_we;
            ms_mem_req_r  <= es_mem_req;
            ms_load_op_r  <= es_load_op;
            ms_csr_re_r   <= es_csr_re;
            ms_ex_zip_r   <= es_ex_zip;
            ms_tlb_zip_r  <= es_tlb_zip;
            ms_tlb_exc_r  <= es_tlb_exc;
        end
    end

    // Park a response that arrives while WS is stalled.
    // The SRAM does not hold rdata after data_ok.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_data  <= 32'b0;
        end else if (wb_flush | ms_leave) begin
            buf_valid <= 1'b0;
        end else if (data_ok_hit & ms_valid & ms_mem_req_r & !ws_allowin & !buf_valid) begin
            buf_valid <= 1'b1;
            buf_data  <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= 2'd0;
        end else if (disc_inc & !disc_dec) begin
            if (discard_cnt != 2'd2) begin
                discard_cnt <= discard_cnt + 2'd1;
            end
        end else if (disc_dec & !disc_inc) begin
            discard_cnt <= discard_cnt - 2'd1;
        end
    end

    assign load_src  = buf_valid ? buf_data : data_sram_rdata;
    assign load_off  = ms_result_r[1:0];
    assign load_half = load_off[1] ? load_src[31:16] : load_src[15:0];

    always_comb begin
        load_byte = load_src[7:0];
        case (load_off)
            2'd0: load_byte = load_src[7:0];
            2'd1: load_byte = load_src[15:8];
            2'd2: load_byte = load_src[23:16];
            2'd3: load_byte = load_src[31:24];
        endcase
    end

    always_comb begin
        load_data = 32'b0;
        if (ms_load_op_r[LD_W]) begin
            load_data = load_src;
        end else if (ms_load_op_r[LD_HU]) begin
            load_data = {16'b0, load_half};
        end else if (ms_load_op_r[LD_H]) begin
            load_data = {{16{load_half[15]}}, load_half};
        end else if (ms_load_op_r[LD_BU]) begin
            load_data = {24'b0, load_byte};
        end else if (ms_load_op_r[LD_B]) begin
            load_data = {{24{load_byte[7]}}, load_byte};
        end
    end

    assign ms_pc         = ms_pc_r;
    assign ms_result     = ms_result_r;
    assign ms_rf_waddr   = ms_rf_waddr_r;
    assign ms_csr_re     = ms_csr_re_r;
    assign ms_ex_zip     = ms_ex_zip_r;
    assign ms2ws_tlb_zip = ms_tlb_zip_r;
    assign ms2ws_tlb_exc = ms_tlb_exc_r;
    assign ms_rf_wdata   = (|ms_load_op_r) ? load_data : ms_result_r;
    assign ms_rf_we      = ms_rf_we_r & ms_valid & !ex_flag & !tlb_flag;

    assign ms_fwd_we     = ms_rf_we;
    assign ms_fwd_waddr  = ms_rf_waddr;
    assign ms_fwd_wdata  = ms_rf_wdata;

    assign ms_load_stall = ms_valid & (|ms_load_op_r) & !ms_ready_go;
    assign ms_ex_pending = ms_valid & (ex_flag | ms_ex_zip_r[ERTN_BIT] | tlb_flag);

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: table of load-extraction vectors, hand sequences for the
// multi-cycle cases (stall, buffering, flush discard, reset), then a randomized run
// compared against a transaction-level model of outstanding responses.
module tb_mem_stage;

    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_B   = 5'b00001;
    localparam logic [4:0] OP_BU  = 5'b00010;
    localparam logic [4:0] OP_H   = 5'b00100;
    localparam logic [4:0] OP_HU  = 5'b01000;
    localparam logic [4:0] OP_W   = 5'b10000;

    logic        clk;
    logic        reset;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [4:0]  es_rf_waddr;
    logic        es_rf_we;
    logic        es_mem_req;
    logic [4:0]  es_load_op;
    logic        es_csr_re;
    logic [86:0] es_ex_zip;
    logic [9:0]  es_tlb_zip;
    logic [7:0]  es_tlb_exc;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        wb_flush;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_rf_wdata;
    logic [4:0]  ms_rf_waddr;
    logic        ms_rf_we;
    logic [31:0] ms_result;
    logic        ms_csr_re;
    logic [86:0] ms_ex_zip;
    logic [9:0]  ms2ws_tlb_zip;
    logic [7:0]  ms2ws_tlb_exc;
    logic        ms_fwd_we;
    logic [4:0]  ms_fwd_waddr;
    logic [31:0] ms_fwd_wdata;
    logic        ms_load_stall;
    logic        ms_ex_pending;

    int nvec = 0;
    int nerr = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
        .es_pc(es_pc), .es_result(es_result), .es_rf_waddr(es_rf_waddr), .es_rf_we(es_rf_we),
        .es_mem_req(es_mem_req), .es_load_op(es_load_op), .es_csr_re(es_csr_re),
        .es_ex_zip(es_ex_zip), .es_tlb_zip(es_tlb_zip), .es_tlb_exc(es_tlb_exc),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ws_allowin(ws_allowin), .wb_flush(wb_flush), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_pc(ms_pc), .ms_rf_wdata(ms_rf_wdata), .ms_rf_waddr(ms_rf_waddr), .ms_rf_we(ms_rf_we),
        .ms_result(ms_result), .ms_csr_re(ms_csr_re), .ms_ex_zip(ms_ex_zip),
        .ms2ws_tlb_zip(ms2ws_tlb_zip), .ms2ws_tlb_exc(ms2ws_tlb_exc), .ms_fwd_we(ms_fwd_we),
        .ms_fwd_waddr(ms_fwd_waddr), .ms_fwd_wdata(ms_fwd_wdata), .ms_load_stall(ms_load_stall),
        .ms_ex_pending(ms_ex_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_zip(input string name, input logic [86:0] act, input logic [86:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        es_pc             = 32'b0;
        es_result         = 32'b0;
        es_rf_waddr       = 5'b0;
        es_rf_we          = 1'b0;
        es_mem_req        = 1'b0;
        es_load_op        = 5'b0;
        es_csr_re         = 1'b0;
        es_ex_zip         = 87'b0;
        es_tlb_zip        = 10'b0;
        es_tlb_exc        = 8'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'b0;
        wb_flush          = 1'b0;
        ws_allowin        = 1'b1;
    endtask

    // Present one instruction to MS; the caller ticks it in and then drops es_to_ms_valid.
    task automatic put(input logic [4:0] op, input logic [31:0] res, input logic mem);
        es_to_ms_valid = 1'b1;
        es_pc          = 32'h1C00_0000 + res;
        es_result      = res;
        es_rf_waddr    = 5'd7;
        es_rf_we       = 1'b1;
        es_mem_req     = mem;
        es_load_op     = op;
        es_ex_zip      = 87'b0;
        es_tlb_exc     = 8'b0;
    endtask

    task automatic enter(input logic [4:0] op, input logic [31:0] res, input logic mem);
        put(op, res, mem);
        tick();
        es_to_ms_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Load extraction written from the rules with shifts and masks.
    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] off,
                                             input logic [31:0] w);
        int unsigned o;
        logic [31:0] b;
        logic [31:0] h;
        o = off;
        b = (w >> (8 * o)) & 32'hFF;
        h = (w >> (16 * (o / 2))) & 32'hFFFF;
        case (op)
            OP_B:    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
            OP_BU:   return b;
            OP_H:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
            OP_HU:   return h;
            OP_W:    return w;
            default: return 32'b0;
        endcase
    endfunction

    typedef struct {
        logic [4:0]  op;
        logic [31:0] res;
        logic        mem;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  waddr;
        logic        we;
        logic        mem;
        logic [4:0]  op;
        logic        csr_re;
        logic [86:0] ex;
        logic [9:0]  tz;
        logic [7:0]  te;
    } inst_t;

    // Model state: MS occupancy plus one flag per outstanding response (1 = owned by MS, 0 = flushed).
    bit    m_valid;
    inst_t m;
    bit    m_have;
    logic [31:0] m_data;
    bit    resp_q[$];

    task automatic random_run(input int cycles);
        bit got;
        bit live;
        bit ready;
        bit e_to_ws;
        bit e_allow;
        int outst;
        int r;
        logic [95:0] wide;
        logic [31:0] src;
        logic [31:0] e_wdata;
        for (int c = 0; c < cycles; c++) begin
            got  = (resp_q.size() > 0) && ($urandom % 3 == 0);
            live = got && resp_q[0];
            outst = resp_q.size() - (got ? 1 : 0);
            data_sram_data_ok = got;
            data_sram_rdata   = $urandom;
            wb_flush          = ($urandom % 16 == 0);
            ws_allowin        = ($urandom % 4 != 0);
            es_to_ms_valid    = !wb_flush && ($urandom % 2 == 1);
            r = $urandom % 4;
            es_load_op  = (r < 2) ? OP_ALU : 5'(5'b00001 << $urandom_range(0, 4));
            es_mem_req  = (r >= 2) && (outst < 2);
            if (r == 3) es_load_op = OP_ALU;            // store: request, no load data
            if (!es_mem_req) es_load_op = OP_ALU;
            es_pc       = $urandom;
            es_result   = $urandom;
            es_rf_waddr = 5'($urandom);
            es_rf_we    = 1'($urandom);
            es_csr_re   = 1'($urandom);
            wide        = {$urandom, $urandom, $urandom};
            es_ex_zip   = wide[86:0];
            if ($urandom % 8 != 0) es_ex_zip[7:0] = 8'b0;
            es_tlb_zip  = 10'($urandom);
            es_tlb_exc  = ($urandom % 10 == 0) ? 8'($urandom) : 8'b0;
            #1;
            ready   = !m.mem || m_have || live;
            e_to_ws = m_valid && ready;
            e_allow = !m_valid || (ready && ws_allowin);
            chk("rnd_to_ws", 32'(ms_to_ws_valid), 32'(e_to_ws));
            chk("rnd_allowin", 32'(ms_allowin), 32'(e_allow));
            chk("rnd_load_stall", 32'(ms_load_stall), 32'(m_valid && (m.op != 0) && !ready));
            chk("rnd_ex_pending", 32'(ms_ex_pending), 32'(m_valid && ((m.ex[7:0] != 0) || (m.te != 0))));
            chk("rnd_rf_we", 32'(ms_rf_we), 32'(m_valid && m.we && (m.ex[6:0] == 0) && (m.te == 0)));
            chk("rnd_fwd_we", 32'(ms_fwd_we), 32'(m_valid && m.we && (m.ex[6:0] == 0) && (m.te == 0)));
            if (m_valid) begin
                chk("rnd_pc", ms_pc, m.pc);
                chk("rnd_result", ms_result, m.res);
                chk("rnd_waddr", 32'(ms_fwd_waddr), 32'(m.waddr));
                chk("rnd_csr_re", 32'(ms_csr_re), 32'(m.csr_re));
                chk_zip("rnd_ex_zip", ms_ex_zip, m.ex);
                chk("rnd_tlb", {14'b0, ms2ws_tlb_zip, ms2ws_tlb_exc}, {14'b0, m.tz, m.te});
                if (ready) begin
                    src     = m_have ? m_data : data_sram_rdata;
                    e_wdata = (m.op != 0) ? ref_load(m.op, m.res[1:0], src) : m.res;
                    chk("rnd_rf_wdata", ms_rf_wdata, e_wdata);
                    chk("rnd_fwd_wdata", ms_fwd_wdata, e_wdata);
                end
            end
            // advance the model to the state after this clock edge
            if (got) void'(resp_q.pop_front());
            if (wb_flush) begin
                foreach (resp_q[i]) resp_q[i] = 1'b0;
                m_valid = 1'b0;
                m_have  = 1'b0;
            end else if (e_allow) begin
                m_valid = es_to_ms_valid;
                m_have  = 1'b0;
                if (es_to_ms_valid) begin
                    m = '{es_pc, es_result, es_rf_waddr, es_rf_we, es_mem_req, es_load_op,
                          es_csr_re, es_ex_zip, es_tlb_zip, es_tlb_exc};
                    if (es_mem_req) resp_q.push_back(1'b1);
                end
            end else if (live) begin
                m_have = 1'b1;
                m_data = data_sram_rdata;
            end
            tick();
        end
    endtask

    initial begin
        vec_t tbl[9];
        logic [86:0] zip;

        tbl[0] = '{OP_ALU, 32'h0000_1234, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234};
        tbl[1] = '{OP_B,   32'h0000_0100, 1'b1, 32'h1234_5680, 32'hFFFF_FF80};
        tbl[2] = '{OP_BU,  32'h0000_0201, 1'b1, 32'h1234_A578, 32'h0000_00A5};
        tbl[3] = '{OP_B,   32'h0000_0302, 1'b1, 32'h127F_0000, 32'h0000_007F};
        tbl[4] = '{OP_BU,  32'h0000_0403, 1'b1, 32'hC000_0000, 32'h0000_00C0};
        tbl[5] = '{OP_H,   32'h0000_0500, 1'b1, 32'h0000_8001, 32'hFFFF_8001};
        tbl[6] = '{OP_H,   32'h0000_0603, 1'b1, 32'h7FFE_1234, 32'h0000_7FFE};
        tbl[7] = '{OP_HU,  32'h0000_0701, 1'b1, 32'h0000_F00D, 32'h0000_F00D};
        tbl[8] = '{OP_W,   32'h0000_0800, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

        idle();
        es_ex_zip = '1;
        es_result = 32'hFFFF_FFFF;
        do_reset();
        idle();
        #1;
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_to_ws", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_rf_wdata", ms_rf_wdata, 32'd0);
        chk("rst_rf_we", 32'(ms_rf_we), 32'd0);
        chk("rst_stall", 32'(ms_load_stall), 32'd0);
        chk("rst_ex_pending", 32'(ms_ex_pending), 32'd0);
        chk_zip("rst_ex_zip", ms_ex_zip, 87'd0);

        // single-cycle loads at every offset / width, plus an ALU op
        for (int i = 0; i < 9; i++) begin
            enter(tbl[i].op, tbl[i].res, tbl[i].mem);
            data_sram_data_ok = tbl[i].mem;
            data_sram_rdata   = tbl[i].rdata;
            #1;
            chk("tbl_to_ws", 32'(ms_to_ws_valid), 32'd1);
            chk("tbl_rf_wdata", ms_rf_wdata, tbl[i].exp);
            chk("tbl_fwd_wdata", ms_fwd_wdata, tbl[i].exp);
            chk("tbl_result", ms_result, tbl[i].res);
            chk("tbl_rf_we", 32'(ms_rf_we), 32'd1);
            tick();
            data_sram_data_ok = 1'b0;
        end

        // load waits two cycles for data
        enter(OP_B, 32'h0000_0003, 1'b1);
        chk("stall_c1", 32'(ms_load_stall), 32'd1);
        chk("stall_c1_to_ws", 32'(ms_to_ws_valid), 32'd0);
        tick();
        chk("stall_c2", 32'(ms_load_stall), 32'd1);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0000;
        #1;
        chk("stall_release", 32'(ms_load_stall), 32'd0);
        chk("stall_to_ws", 32'(ms_to_ws_valid), 32'd1);
        chk("stall_wdata", ms_rf_wdata, 32'hFFFF_FF80);
        tick();
        data_sram_data_ok = 1'b0;

        // response arrives while WS stalls; SRAM output changes afterwards
        enter(OP_HU, 32'h0000_0002, 1'b1);
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_1234;
        #1;
        chk("buf_c0_allowin", 32'(ms_allowin), 32'd0);
        chk("buf_c0_wdata", ms_rf_wdata, 32'h0000_80FF);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h1111_2222;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("buf_hold_to_ws", 32'(ms_to_ws_valid), 32'd1);
            chk("buf_hold_allowin", 32'(ms_allowin), 32'd0);
            chk("buf_hold_wdata", ms_rf_wdata, 32'h0000_80FF);
            tick();
        end
        ws_allowin = 1'b1;
        #1;
        chk("buf_rel_allowin", 32'(ms_allowin), 32'd1);
        chk("buf_rel_wdata", ms_rf_wdata, 32'h0000_80FF);
        tick();
        chk("buf_after_to_ws", 32'(ms_to_ws_valid), 32'd0);

        // flush while waiting: the stale response is dropped
        enter(OP_W, 32'h0000_0010, 1'b1);
        chk("fl1_wait", 32'(ms_load_stall), 32'd1);
        tick();
        wb_flush = 1'b1;
        tick();
        wb_flush = 1'b0;
        chk("fl1_to_ws", 32'(ms_to_ws_valid), 32'd0);
        chk("fl1_allowin", 32'(ms_allowin), 32'd1);
        enter(OP_W, 32'h0000_0020, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_BAD0;
        #1;
        chk("fl1_drop_to_ws", 32'(ms_to_ws_valid), 32'd0);
        chk("fl1_drop_stall", 32'(ms_load_stall), 32'd1);
        tick();
        data_sram_rdata = 32'h600D_F00D;
        #1;
        chk("fl1_next_to_ws", 32'(ms_to_ws_valid), 32'd1);
        chk("fl1_next_wdata", ms_rf_wdata, 32'h600D_F00D);
        tick();
        data_sram_data_ok = 1'b0;

        // flush in the same cycle as the response: nothing left to discard
        enter(OP_W, 32'h0000_0030, 1'b1);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_0BAD;
        wb_flush          = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        wb_flush          = 1'b0;
        chk("fl2_to_ws", 32'(ms_to_ws_valid), 32'd0);
        chk("fl2_allowin", 32'(ms_allowin), 32'd1);
        enter(OP_BU, 32'h0000_0001, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_7F00;
        #1;
        chk("fl2_next_to_ws", 32'(ms_to_ws_valid), 32'd1);
        chk("fl2_next_wdata", ms_rf_wdata, 32'h0000_007F);
        tick();
        data_sram_data_ok = 1'b0;

        // two flushed requests in flight: two responses dropped, third accepted
        enter(OP_W, 32'h0000_0040, 1'b1);
        wb_flush = 1'b1;
        tick();
        wb_flush = 1'b0;
        enter(OP_W, 32'h0000_0044, 1'b1);
        chk("fl3_wait", 32'(ms_load_stall), 32'd1);
        wb_flush = 1'b1;
        tick();
        wb_flush = 1'b0;
        enter(OP_H, 32'h0000_0048, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        #1;
        chk("fl3_drop1", 32'(ms_to_ws_valid), 32'd0);
        tick();
        data_sram_rdata = 32'h2222_2222;
        #1;
        chk("fl3_drop2", 32'(ms_to_ws_valid), 32'd0);
        tick();
        data_sram_rdata = 32'h0000_9ABC;
        #1;
        chk("fl3_take", 32'(ms_to_ws_valid), 32'd1);
        chk("fl3_wdata", ms_rf_wdata, 32'hFFFF_9ABC);
        tick();
        data_sram_data_ok = 1'b0;

        // exception payloads
        zip = {1'b1, 14'h00A, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 7'b000_0001};
        put(OP_ALU, 32'h0000_0050, 1'b0);
        es_ex_zip = zip;
        tick();
        es_to_ms_valid = 1'b0;
        chk("sys_ex_pending", 32'(ms_ex_pending), 32'd1);
        chk("sys_rf_we", 32'(ms_rf_we), 32'd0);
        chk("sys_fwd_we", 32'(ms_fwd_we), 32'd0);
        chk_zip("sys_ex_zip", ms_ex_zip, zip);
        tick();
        put(OP_ALU, 32'h0000_0054, 1'b0);
        es_tlb_exc = 8'h20;
        es_tlb_zip = 10'h2A5;
        tick();
        es_to_ms_valid = 1'b0;
        chk("tlb_ex_pending", 32'(ms_ex_pending), 32'd1);
        chk("tlb_rf_we", 32'(ms_rf_we), 32'd0);
        chk("tlb_pass", {14'b0, ms2ws_tlb_zip, ms2ws_tlb_exc}, {14'b0, 10'h2A5, 8'h20});
        tick();
        put(OP_ALU, 32'h0000_0058, 1'b0);
        es_ex_zip = 87'h80;
        tick();
        es_to_ms_valid = 1'b0;
        chk("ertn_ex_pending", 32'(ms_ex_pending), 32'd1);
        tick();
        enter(OP_ALU, 32'h0000_005C, 1'b0);
        chk("alu_ex_pending", 32'(ms_ex_pending), 32'd0);
        chk("alu_rf_we", 32'(ms_rf_we), 32'd1);
        chk("alu_fwd_waddr", 32'(ms_fwd_waddr), 32'd7);
        tick();

        // reset while a flushed response is outstanding clears the discard state
        enter(OP_W, 32'h0000_0060, 1'b1);
        wb_flush = 1'b1;
        tick();
        wb_flush = 1'b0;
        do_reset();
        chk("mid_rst_allowin", 32'(ms_allowin), 32'd1);
        enter(OP_W, 32'h0000_0064, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_0001;
        #1;
        chk("mid_rst_to_ws", 32'(ms_to_ws_valid), 32'd1);
        chk("mid_rst_wdata", ms_rf_wdata, 32'hCAFE_0001);
        tick();

        // randomized traffic from a clean state
        idle();
        do_reset();
        m_valid = 1'b0;
        m_have  = 1'b0;
        m       = '{32'b0, 32'b0, 5'b0, 1'b0, 1'b0, 5'b0, 1'b0, 87'b0, 10'b0, 8'b0};
        resp_q.delete();
        random_run(2000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
